// File: rtl/noc_pkg.sv
// Shared NoC router types, constants and width helpers.
package noc_pkg;

  localparam int PortQueueDepth = 5;
  localparam int MaxVc          = 8;

  typedef enum logic {
    kFlowControlCreditBased,
    kFlowControlAckNack
  } noc_flow_control_t;

  typedef logic [$clog2(MaxVc)-1:0] vc_id_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  function automatic int credits_width(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int vc_width(int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  localparam int CreditsWidth = credits_width(PortQueueDepth);

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter; the pointer names the first requester searched and
// moves to the one after the winner whenever the grant is consumed.
module noc_rr_arbiter #(
  parameter  int NumReq = 2,
  localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              advance,
  output logic [NumReq-1:0] gnt
);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == NumReq - 1) ? '0 : PtrW'(idx + 1);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/noc_vc_output_port.sv
// Router output port: per-VC arbitration with wormhole lock, downstream
// credit tracking and a registered single-flit link output.
module noc_vc_output_port
  import noc_pkg::*;
#(
  parameter  int                NumVc       = 2,
  parameter  int                DataWidth   = 64,
  parameter  int                VcDepth     = PortQueueDepth,
  parameter  noc_flow_control_t FlowControl = kFlowControlCreditBased,
  localparam int                VcW         = vc_width(NumVc),
  localparam int                CW          = credits_width(VcDepth),
  localparam int                FW          = $bits(preamble_t) + DataWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumVc-1:0]         in_valid,
  input  logic [NumVc-1:0][FW-1:0] in_flit,
  output logic [NumVc-1:0]         in_ready,
  output logic                     out_valid,
  output logic [FW-1:0]            out_flit,
  output logic [VcW-1:0]           out_vc,
  input  logic [NumVc-1:0]         credit_in,
  output logic [NumVc-1:0][CW-1:0] credits
);

  typedef struct packed {
    preamble_t            preamble;
    logic [DataWidth-1:0] payload;
  } flit_t;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e             state_q, state_d;
  vc_id_t                  lock_vc_q, lock_vc_d;
  logic [NumVc-1:0][CW-1:0] cred_q, cred_d;
  logic                    out_valid_q, out_valid_d;
  flit_t                   out_flit_q, out_flit_d;
  logic [VcW-1:0]          out_vc_q, out_vc_d;

  logic [NumVc-1:0] eligible, req, gnt;
  logic [VcW-1:0]   gnt_idx;
  flit_t            sel_flit;
  logic             send_any, credit_ovf, body_unlocked;

  // In credit mode eligibility looks only at registered counts, so credit_in
  // never reaches the grant; in ack/nack mode the level gates it directly.
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NumVc; v++) begin
      if (FlowControl == kFlowControlCreditBased) eligible[v] = in_valid[v] && (cred_q[v] != '0);
      else                                        eligible[v] = in_valid[v] && credit_in[v];
    end
    req = (state_q == LOCKED) ? (eligible & (NumVc'(1) << lock_vc_q)) : eligible;
    req = req & {NumVc{rst}};
  end

  noc_rr_arbiter #(.NumReq(NumVc)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (send_any),
    .gnt     (gnt)
  );

  assign send_any = |gnt;
  assign in_ready = gnt;

  always_comb begin
    gnt_idx = '0;
    for (int v = 0; v < NumVc; v++) if (gnt[v]) gnt_idx = VcW'(v);
  end

  assign sel_flit = flit_t'(in_flit[gnt_idx]);

  always_comb begin
    state_d       = state_q;
    lock_vc_d     = lock_vc_q;
    body_unlocked = 1'b0;
    if (send_any) begin
      if (sel_flit.preamble.tail) state_d = UNLOCKED;
      else if (sel_flit.preamble.head) begin
        state_d   = LOCKED;
        lock_vc_d = vc_id_t'(gnt_idx);
      end else body_unlocked = (state_q == UNLOCKED);
    end
  end

  always_comb begin
    cred_d     = cred_q;
    credit_ovf = 1'b0;
    if (FlowControl == kFlowControlCreditBased) begin
      for (int v = 0; v < NumVc; v++) begin
        if (gnt[v] && !credit_in[v]) cred_d[v] = cred_q[v] - CW'(1);
        else if (credit_in[v] && !gnt[v]) begin
          if (cred_q[v] == CW'(VcDepth)) credit_ovf = 1'b1;
          else                           cred_d[v]  = cred_q[v] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    out_valid_d = send_any;
    out_flit_d  = out_flit_q;
    out_vc_d    = out_vc_q;
    if (send_any) begin
      out_flit_d = sel_flit;
      out_vc_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      lock_vc_q   <= '0;
      cred_q      <= {NumVc{CW'(VcDepth)}};
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_vc_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_vc_q   <= lock_vc_d;
      cred_q      <= cred_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_vc_q    <= out_vc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign out_vc    = out_vc_q;
  assign credits   = cred_q;

  always @(posedge clk) begin
    if (rst) begin
      assert (!credit_ovf) else $warning("credit return with counter already full");
      assert (!body_unlocked) else $warning("body flit without an open packet");
    end
  end

endmodule

// File: tb/tb_noc_vc_output_port.sv
// Bench for noc_vc_output_port: a credit-mode and an ack/nack-mode instance
// checked every cycle against a queue-level model plus directed literals.
module tb_noc_vc_output_port;
  import noc_pkg::*;

  localparam int N = 2, DW = 8, D = 5, FW = DW + 2, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // index 0: credit-mode DUT, index 1: ack/nack-mode DUT
  logic [N-1:0]          iv  [2];
  logic [N-1:0][FW-1:0]  ifl [2];
  logic [N-1:0]          ci  [2];
  logic [N-1:0]          rdy [2];
  logic                  ov  [2];
  logic [FW-1:0]         ofl [2];
  logic [0:0]            ovc [2];
  logic [N-1:0][CW-1:0]  cr  [2];

  noc_vc_output_port #(.NumVc(N), .DataWidth(DW), .VcDepth(D),
                       .FlowControl(kFlowControlCreditBased)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_flit(ifl[0]), .in_ready(rdy[0]),
    .out_valid(ov[0]), .out_flit(ofl[0]), .out_vc(ovc[0]), .credit_in(ci[0]), .credits(cr[0]));

  noc_vc_output_port #(.NumVc(N), .DataWidth(DW), .VcDepth(D),
                       .FlowControl(kFlowControlAckNack)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_flit(ifl[1]), .in_ready(rdy[1]),
    .out_valid(ov[1]), .out_flit(ofl[1]), .out_vc(ovc[1]), .credit_in(ci[1]), .credits(cr[1]));

  // model state
  int            mcred [2][N];
  bit            mlock [2];
  int            mlvc  [2];
  int            mptr  [2];
  bit            mov   [2];
  int            movc  [2];
  logic [FW-1:0] mof   [2];

  // per-VC source queues feeding the crossbar side
  logic [FW-1:0] sbuf [2][N][16];
  int            rd   [2][N];
  int            wr   [2][N];
  bit            auto_ret [2];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit elig(int m, int v);
    if (!iv[m][v]) return 1'b0;
    return (m == 0) ? (mcred[m][v] > 0) : bit'(ci[m][v]);
  endfunction

  function automatic int model_grant(int m);
    if (!rst) return -1;
    if (mlock[m]) return elig(m, mlvc[m]) ? mlvc[m] : -1;
    for (int i = 0; i < N; i++) begin
      int v;
      v = (mptr[m] + i) % N;
      if (elig(m, v)) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < N; v++) mcred[m][v] = D;
      mlock[m] = 0; mlvc[m] = 0; mptr[m] = 0;
      mov[m] = 0; movc[m] = 0; mof[m] = '0;
    end
  endtask

  task automatic model_update(input int m, input int g);
    logic [FW-1:0] f;
    if (m == 0)
      for (int v = 0; v < N; v++) begin
        bit s, c;
        s = (g == v);
        c = ci[m][v];
        if (s && !c) mcred[m][v]--;
        else if (c && !s && mcred[m][v] < D) mcred[m][v]++;
      end
    mov[m] = (g >= 0);
    if (g >= 0) begin
      f = ifl[m][g];
      movc[m] = g;
      mof[m]  = f;
      if (f[FW-2]) mlock[m] = 0;
      else if (f[FW-1]) begin mlock[m] = 1; mlvc[m] = g; end
      mptr[m] = (g + 1) % N;
    end
  endtask

  task automatic drive_inputs();
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < N; v++) begin
        iv[m][v]  = rd[m][v] < wr[m][v];
        ifl[m][v] = iv[m][v] ? sbuf[m][v][rd[m][v]] : '0;
      end
  endtask

  task automatic push(input int m, input int v, input bit h, input bit t, input logic [7:0] p);
    sbuf[m][v][wr[m][v]] = {h, t, p};
    wr[m][v]++;
    drive_inputs();
  endtask

  task automatic clear_src();
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < N; v++) begin rd[m][v] = 0; wr[m][v] = 0; end
    drive_inputs();
  endtask

  // One clock: model follows the DUT edge, then sources pop and inputs move.
  task automatic tick();
    int g[2];
    @(posedge clk);
    for (int m = 0; m < 2; m++) g[m] = model_grant(m);
    if (rst) for (int m = 0; m < 2; m++) model_update(m, g[m]);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (g[m] >= 0) rd[m][g[m]]++;
      if (auto_ret[m]) for (int v = 0; v < N; v++) ci[m][v] = (g[m] == v);
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    ci[0] = '0; ci[1] = '1;
    auto_ret[0] = 0; auto_ret[1] = 0;
    clear_src();
    tick();
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    int g;
    logic [N-1:0] e;
    for (int m = 0; m < 2; m++) begin
      g = model_grant(m);
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      chk($sformatf("in_ready[dut%0d]", m), rdy[m], e);
      chk($sformatf("out_valid[dut%0d]", m), ov[m], mov[m]);
      if (mov[m]) begin
        chk($sformatf("out_vc[dut%0d]", m), ovc[m], movc[m]);
        chk($sformatf("out_flit[dut%0d]", m), ofl[m], mof[m]);
      end
      for (int v = 0; v < N; v++)
        chk($sformatf("credits[dut%0d][%0d]", m, v), cr[m][v], mcred[m][v]);
    end
  end

  initial begin
    int cnt;
    do_reset();

    // alternating single-flit packets with prompt credit return
    auto_ret[0] = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 1, 1, 8'h10 + 8'(i));
      push(0, 1, 1, 1, 8'h20 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr out_valid", ov[0], 1);
      chk("rr out_vc", ovc[0], i % 2);
      chk("rr payload", ofl[0][7:0], (i % 2) ? 8'h20 + i / 2 : 8'h10 + i / 2);
    end

    // wormhole packet on VC0 holds the link against a waiting VC1
    do_reset();
    auto_ret[0] = 1;
    push(0, 0, 1, 0, 8'h30); push(0, 0, 0, 0, 8'h31);
    push(0, 0, 0, 0, 8'h32); push(0, 0, 0, 1, 8'h33);
    push(0, 1, 1, 1, 8'h40); push(0, 1, 1, 1, 8'h41);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lock out_vc", ovc[0], (i < 4) ? 0 : 1);
      chk("lock payload", ofl[0][7:0], (i < 4) ? 8'h30 + i : 8'h40 + i - 4);
    end

    // credit exhaustion, then one returned credit lets exactly one flit out
    do_reset();
    for (int i = 0; i < 7; i++) push(0, 0, 1, 1, 8'h50 + 8'(i));
    cnt = 0;
    for (int i = 0; i < 7; i++) begin tick(); cnt += int'(ov[0]); end
    chk("flits before stall", cnt, 5);
    chk("credits empty", cr[0][0], 0);
    chk("in_ready stalled", rdy[0][0], 0);
    ci[0][0] = 1'b1; tick(); ci[0][0] = 1'b0;
    chk("credit landed", cr[0][0], 1);
    tick();
    chk("extra flit valid", ov[0], 1);
    chk("extra flit payload", ofl[0][7:0], 8'h55);
    cnt = 0;
    repeat (3) begin tick(); cnt += int'(ov[0]); end
    chk("no further flits", cnt, 0);

    // same-cycle send and return, then saturation at full
    do_reset();
    for (int i = 0; i < 3; i++) push(0, 0, 1, 1, 8'h60 + 8'(i));
    tick(); tick();
    chk("credits after two sends", cr[0][0], 3);
    ci[0] = 2'b01; tick();
    chk("send+return keeps count", cr[0][0], 3);
    chk("send+return flit", ofl[0][7:0], 8'h62);
    tick(); chk("return to 4", cr[0][0], 4);
    tick(); chk("return to 5", cr[0][0], 5);
    #1 chk("overflow flagged", dut_c.credit_ovf, 1);
    tick(); chk("saturated at depth", cr[0][0], 5);
    ci[0] = '0;

    // ack/nack: locked VC1 blocked, VC0 must wait for VC1's tail
    do_reset();
    push(1, 1, 1, 0, 8'h70); push(1, 1, 0, 0, 8'h71);
    push(1, 1, 0, 0, 8'h72); push(1, 1, 0, 1, 8'h73);
    tick();
    chk("an head vc", ovc[1], 1);
    chk("an head payload", ofl[1][7:0], 8'h70);
    push(1, 0, 1, 1, 8'h7f);
    ci[1] = 2'b01;
    #1 chk("an blocked in_ready", rdy[1], 0);
    tick(); chk("an bubble 1", ov[1], 0);
    tick(); chk("an bubble 2", ov[1], 0);
    ci[1] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("an resume vc", ovc[1], 1);
      chk("an resume payload", ofl[1][7:0], 8'h71 + i);
    end
    tick();
    chk("an vc0 after tail", ovc[1], 0);
    chk("an vc0 payload", ofl[1][7:0], 8'h7f);

    // reset right after a head flit abandons the packet and clears the lock
    do_reset();
    push(0, 0, 1, 0, 8'h90); push(0, 0, 0, 0, 8'h91); push(0, 0, 0, 1, 8'h92);
    tick();
    chk("pre-reset head", ofl[0][7:0], 8'h90);
    chk("pre-reset credits", cr[0][0], 4);
    rst = 1'b0;
    model_reset();
    clear_src();
    push(0, 1, 1, 1, 8'ha0);
    #1;
    chk("reset out_valid", ov[0], 0);
    chk("reset credits", cr[0][0], 5);
    chk("reset in_ready", rdy[0], 0);
    tick();
    rst = 1'b1;
    #1 chk("post-reset grant", rdy[0], 2'b10);
    tick();
    chk("post-reset vc", ovc[0], 1);
    chk("post-reset payload", ofl[0][7:0], 8'ha0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
